// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : N-input valid/ready mux, explicit-select or round-robin
//                 mode, one-deep registered output stage and transfer counter.
// Revision      : 1.0
// ============================================================================
module stream_mux_rr #(
  parameter int N  = 9,
  parameter int W  = 1,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [$clog2(N)-1:0]  sel,
  input  logic [N-1:0]          in_valid,
  input  logic [N*W-1:0]        in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  input  logic                  out_ready,
  input  logic                  clr_err,
  output logic                  sel_err,
  output logic [CW-1:0]         xfer_cnt
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0] C_N = (SW+1)'(N);

  logic [W-1:0]   w_ch [N];
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_off;
  logic [SW:0]    w_sum;
  logic [SW-1:0]  w_rr_g;
  logic [SW-1:0]  w_g;
  logic           w_gv;
  logic           w_sel_ok;
  logic           w_load;
  logic           w_xfer;

  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_sel_err;
  logic [CW-1:0]  r_xfer_cnt;
  logic [SW-1:0]  r_ptr;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_ch[k] = in_data[k*W +: W];
  end

  // Rotate the valid vector so bit 0 is the pointer's channel, then find the
  // lowest set bit and map the offset back to an absolute channel index.
  always_comb begin
    w_dbl = {in_valid, in_valid} >> r_ptr;
    w_rot = w_dbl[N-1:0];
    w_off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[SW-1:0];
    end
    w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    w_rr_g = (w_sum >= C_N) ? SW'(w_sum - C_N) : w_sum[SW-1:0];
  end

  always_comb begin
    w_sel_ok = ({1'b0, sel} < C_N);
    if (mode) begin
      w_gv = |in_valid;
      w_g  = w_rr_g;
    end else begin
      w_gv = w_sel_ok && in_valid[sel];
      w_g  = sel;
    end
  end

  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_load && w_gv && rst_n;

  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel_err   <= 1'b0;
      r_xfer_cnt  <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_xfer;
        if (w_xfer) r_out_data <= w_ch[w_g];
      end
      if (w_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
        if (mode) r_ptr <= (w_g == SW'(N-1)) ? '0 : w_g + 1'b1;
      end
      // A new out-of-range select outranks a clear in the same cycle.
      if (!mode && !w_sel_ok) r_sel_err <= 1'b1;
      else if (clr_err)       r_sel_err <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel_err   = r_sel_err;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// tb_stream_mux_rr : directed scoreboard bench for stream_mux_rr (N=9, W=8).
// Revision         : 1.0
// ============================================================================
module tb_stream_mux_rr;

  localparam int N  = 9;
  localparam int W  = 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [3:0]     sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           clr_err;
  logic           sel_err;
  logic [CW-1:0]  xfer_cnt;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q [$];

  stream_mux_rr #(.N(N), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .sel_err   (sel_err),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted output word is popped against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_word unexpected actual=%0h expected=none", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_word actual=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  task automatic default_data();
    for (int k = 0; k < N; k++) set_ch(k, 8'h10 + 8'(k));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 4'd0; in_valid = 9'h1FF;
    out_ready = 1'b1; clr_err = 1'b0; in_data = '0;
    default_data();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    chk("rst_sel_err",   32'(sel_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    in_valid = '0;
    tick();

    // Explicit select of channel 3
    sel = 4'd3; in_valid = 9'h008; set_ch(3, 8'hA5);
    #1; chk("sel3_in_ready", 32'(in_ready), 32'h008);
    exp_q.push_back(8'hA5);
    tick();
    in_valid = '0;
    #1;
    chk("sel3_out_valid", 32'(out_valid), 32'd1);
    chk("sel3_out_data",  32'(out_data),  32'hA5);
    chk("sel3_xfer_cnt",  32'(xfer_cnt),  32'd1);

    // Backpressure on channel 0
    tick();
    sel = 4'd0; in_valid = 9'h001; set_ch(0, 8'h01);
    exp_q.push_back(8'h01);
    tick();
    out_ready = 1'b0; set_ch(0, 8'h02);
    #1;
    chk("bp_in_ready",  32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'h01);
    tick();
    #1;
    chk("bp_hold_data2", 32'(out_data),  32'h01);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1; chk("bp_release_ready", 32'(in_ready), 32'h001);
    exp_q.push_back(8'h02);
    tick();
    chk("bp_data02", 32'(out_data), 32'h02);
    set_ch(0, 8'h03);
    exp_q.push_back(8'h03);
    tick();
    chk("bp_data03", 32'(out_data), 32'h03);
    in_valid = '0;
    tick();
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_xfer_cnt",      32'(xfer_cnt),  32'd4);

    // Round-robin with every channel valid: 0..8 then wrap to 0
    default_data();
    mode = 1'b1; in_valid = 9'h1FF;
    for (int c = 0; c < 10; c++) begin
      int g;
      g = c % N;
      #1; chk($sformatf("rr_grant%0d", c), 32'(in_ready), 32'(9'h001 << g));
      exp_q.push_back(8'h10 + 8'(g));
      tick();
    end
    in_valid = '0;
    #1; chk("rr_xfer_cnt", 32'(xfer_cnt), 32'd14);

    // Move pointer to 5 via channel 4, then wrap search over {0,2}
    in_valid = 9'h010;
    #1; chk("rr_ptr_setup", 32'(in_ready), 32'h010);
    exp_q.push_back(8'h14);
    tick();
    in_valid = 9'h005;
    #1; chk("rr_wrap_grant0", 32'(in_ready), 32'h001);
    exp_q.push_back(8'h10);
    tick();
    #1; chk("rr_next_grant2", 32'(in_ready), 32'h004);
    exp_q.push_back(8'h12);
    tick();

    // Out-of-range select
    mode = 1'b0; sel = 4'd12; in_valid = 9'h1FF;
    #1; chk("oor_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("oor_out_valid", 32'(out_valid), 32'd0);
    chk("oor_sel_err",   32'(sel_err),   32'd1);
    clr_err = 1'b1;
    tick();
    chk("oor_set_wins", 32'(sel_err), 32'd1);
    sel = 4'd0; in_valid = '0;
    tick();
    chk("oor_cleared",   32'(sel_err),  32'd0);
    chk("oor_xfer_cnt",  32'(xfer_cnt), 32'd17);
    clr_err = 1'b0;

    // Fresh reset, build cnt=7 / ptr=4 / pending word, then async reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    in_valid = 9'h001;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(8'h10);
      tick();
    end
    mode = 1'b1; in_valid = 9'h1FF;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(8'h10 + 8'(c));
      tick();
    end
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_cnt",   32'(xfer_cnt),  32'd7);
    chk("pre_rst_ptr4",  32'(in_ready),  32'h010);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_cnt",   32'(xfer_cnt),  32'd0);
    chk("async_rst_ready", 32'(in_ready),  32'd0);
    tick();
    chk("rst_hold_cnt", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    #1; chk("post_rst_ptr0", 32'(in_ready), 32'h001);
    exp_q.push_back(8'h10);
    tick();
    in_valid = '0;
    #1;
    chk("post_rst_data", 32'(out_data), 32'h10);
    chk("post_rst_cnt",  32'(xfer_cnt), 32'd1);
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
